// File: rtl/vmx_pe_mp.sv
// vmx_pe_mp: systolic-array processing element with double-buffered weights,
// 1/2/4-lane signed SIMD multiply-accumulate and a two-stage result pipeline.
// Pass-through token signals advance with stage 1; the lane sum leaves stage 2.
module vmx_pe_mp #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 2 * DATA_W,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [1:0]        in_mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_wload,
    input  logic [TAG_W-1:0]  in_wtag,
    input  logic              in_wswap,
    input  logic [ACC_W-1:0]  in_sum,
    output logic              out_valid,
    output logic [1:0]        out_mode,
    output logic [DATA_W-1:0] out_data,
    output logic              out_wload,
    output logic [TAG_W-1:0]  out_wtag,
    output logic              out_wswap,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_sum_valid,
    output logic              err_swap_empty
);

    localparam int H  = DATA_W / 2;
    localparam int Q  = DATA_W / 4;
    localparam int AH = ACC_W / 2;
    localparam int AQ = ACC_W / 4;

    logic [DATA_W-1:0] active_q, active_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic              shadow_full_q, shadow_full_d;
    logic              err_d;
    logic [ACC_W-1:0]  prod_q, prod_d;
    logic [ACC_W-1:0]  sum_q;
    logic [ACC_W-1:0]  lane_sum_s;
    logic              swap_ok_s;
    logic              tag_zero_s;
    logic              load_s;
    logic [DATA_W-1:0] w_op_s;
    logic              wload_d;
    logic [TAG_W-1:0]  wtag_d;

    logic signed [DATA_W-1:0] d1_s, w1_s;
    logic signed [H-1:0]      d2_s, w2_s;
    logic signed [Q-1:0]      d4_s, w4_s;

    // A swap beat computes with the incoming shadow weight, not the stale active one.
    always_comb begin
        tag_zero_s = (in_wtag == {TAG_W{1'b0}});
        load_s     = in_wload & tag_zero_s;
        swap_ok_s  = in_wswap & shadow_full_q;
        if (swap_ok_s) begin
            w_op_s = shadow_q;
        end else begin
            w_op_s = active_q;
        end
    end

    // Weight bank and error flag next state; a concurrent load refills the shadow just vacated.
    always_comb begin
        active_d      = active_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        err_d         = err_swap_empty;
        if (swap_ok_s) begin
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
        end else if (in_wswap) begin
            err_d = 1'b1;
        end else begin
            err_d = err_swap_empty;
        end
        if (load_s) begin
            shadow_d      = in_data;
            shadow_full_d = 1'b1;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Load token forwarding: a token consumed here is not forwarded; otherwise the countdown advances.
    always_comb begin
        if (in_wload && !tag_zero_s) begin
            wload_d = 1'b1;
            wtag_d  = in_wtag - TAG_W'(1);
        end else begin
            wload_d = 1'b0;
            wtag_d  = in_wtag;
        end
    end

    // Signed lane products, each sign-extended to its lane sum width before multiplying
    // so the lane product wraps exactly like the final modulo-2^(ACC_W/L) sum.
    always_comb begin
        prod_d = {ACC_W{1'b0}};
        d1_s   = {DATA_W{1'b0}};
        w1_s   = {DATA_W{1'b0}};
        d2_s   = {H{1'b0}};
        w2_s   = {H{1'b0}};
        d4_s   = {Q{1'b0}};
        w4_s   = {Q{1'b0}};
        case (in_mode)
            2'b01: begin
                for (int i = 0; i < 2; i++) begin
                    d2_s = in_data[i*H +: H];
                    w2_s = w_op_s[i*H +: H];
                    prod_d[i*AH +: AH] = AH'(d2_s) * AH'(w2_s);
                end
            end
            2'b10: begin
                for (int i = 0; i < 4; i++) begin
                    d4_s = in_data[i*Q +: Q];
                    w4_s = w_op_s[i*Q +: Q];
                    prod_d[i*AQ +: AQ] = AQ'(d4_s) * AQ'(w4_s);
                end
            end
            default: begin
                d1_s   = in_data;
                w1_s   = w_op_s;
                prod_d = ACC_W'(d1_s) * ACC_W'(w1_s);
            end
        endcase
    end

    // Stage 2 lane adders; no carry crosses a lane boundary.
    always_comb begin
        lane_sum_s = {ACC_W{1'b0}};
        case (out_mode)
            2'b01: begin
                for (int i = 0; i < 2; i++) begin
                    lane_sum_s[i*AH +: AH] = prod_q[i*AH +: AH] + sum_q[i*AH +: AH];
                end
            end
            2'b10: begin
                for (int i = 0; i < 4; i++) begin
                    lane_sum_s[i*AQ +: AQ] = prod_q[i*AQ +: AQ] + sum_q[i*AQ +: AQ];
                end
            end
            default: begin
                lane_sum_s = prod_q + sum_q;
            end
        endcase
    end

    // All state: banks, flags, stage 1 and stage 2, frozen together whenever en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q       <= {DATA_W{1'b0}};
            shadow_q       <= {DATA_W{1'b0}};
            shadow_full_q  <= 1'b0;
            err_swap_empty <= 1'b0;
            prod_q         <= {ACC_W{1'b0}};
            sum_q          <= {ACC_W{1'b0}};
            out_valid      <= 1'b0;
            out_mode       <= 2'b00;
            out_data       <= {DATA_W{1'b0}};
            out_wload      <= 1'b0;
            out_wtag       <= {TAG_W{1'b0}};
            out_wswap      <= 1'b0;
            out_sum        <= {ACC_W{1'b0}};
            out_sum_valid  <= 1'b0;
        end else if (en) begin
            active_q       <= active_d;
            shadow_q       <= shadow_d;
            shadow_full_q  <= shadow_full_d;
            err_swap_empty <= err_d;
            prod_q         <= prod_d;
            sum_q          <= in_sum;
            out_valid      <= in_valid;
            out_mode       <= in_mode;
            out_data       <= in_data;
            out_wload      <= wload_d;
            out_wtag       <= wtag_d;
            out_wswap      <= in_wswap;
            out_sum_valid  <= out_valid;
            if (out_valid) begin
                out_sum <= lane_sum_s;
            end else begin
                out_sum <= {ACC_W{1'b0}};
            end
        end else begin
            active_q       <= active_q;
            shadow_q       <= shadow_q;
            shadow_full_q  <= shadow_full_q;
            err_swap_empty <= err_swap_empty;
            prod_q         <= prod_q;
            sum_q          <= sum_q;
            out_valid      <= out_valid;
            out_mode       <= out_mode;
            out_data       <= out_data;
            out_wload      <= out_wload;
            out_wtag       <= out_wtag;
            out_wswap      <= out_wswap;
            out_sum        <= out_sum;
            out_sum_valid  <= out_sum_valid;
        end
    end

endmodule

// File: tb/tb_vmx_pe_mp.sv
// Directed bench for vmx_pe_mp (DATA_W=16, ACC_W=32, TAG_W=8) with hand-computed expectations.
module tb_vmx_pe_mp;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        in_valid;
    logic [1:0]  in_mode;
    logic [15:0] in_data;
    logic        in_wload;
    logic [7:0]  in_wtag;
    logic        in_wswap;
    logic [31:0] in_sum;
    logic        out_valid;
    logic [1:0]  out_mode;
    logic [15:0] out_data;
    logic        out_wload;
    logic [7:0]  out_wtag;
    logic        out_wswap;
    logic [31:0] out_sum;
    logic        out_sum_valid;
    logic        err_swap_empty;

    int vectors;
    int miscompares;

    vmx_pe_mp #(.DATA_W(16), .ACC_W(32), .TAG_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(in_valid), .in_mode(in_mode), .in_data(in_data),
        .in_wload(in_wload), .in_wtag(in_wtag), .in_wswap(in_wswap), .in_sum(in_sum),
        .out_valid(out_valid), .out_mode(out_mode), .out_data(out_data),
        .out_wload(out_wload), .out_wtag(out_wtag), .out_wswap(out_wswap),
        .out_sum(out_sum), .out_sum_valid(out_sum_valid), .err_swap_empty(err_swap_empty)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_mode = 2'b00; in_data = 16'h0000;
        in_wload = 1'b0; in_wtag = 8'h00; in_wswap = 1'b0; in_sum = 32'h0;
    endtask

    task automatic beat(input logic v, input logic [1:0] m, input logic [15:0] d,
                        input logic [31:0] s, input logic sw);
        in_valid = v; in_mode = m; in_data = d; in_sum = s; in_wswap = sw;
        in_wload = 1'b0; in_wtag = 8'h00;
    endtask

    task automatic wload(input logic [15:0] d, input logic [7:0] t);
        in_valid = 1'b0; in_mode = 2'b00; in_data = d; in_sum = 32'h0;
        in_wswap = 1'b0; in_wload = 1'b1; in_wtag = t;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        en = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_sum", {32'h0, out_sum}, 64'h0);
        check("reset_sum_valid", {63'h0, out_sum_valid}, 64'h0);
        check("reset_err", {63'h0, err_swap_empty}, 64'h0);
        check("reset_wload", {63'h0, out_wload}, 64'h0);
        rst_n = 1'b1;
        tick();

        // Load then swap: 3*5 + 0x10 = 0x1F
        wload(16'h0003, 8'h00);
        tick();
        check("load_out_wload", {63'h0, out_wload}, 64'h0);
        beat(1'b1, 2'b00, 16'h0005, 32'h10, 1'b1);
        tick();
        check("swap_out_valid", {63'h0, out_valid}, 64'h1);
        check("swap_out_wswap", {63'h0, out_wswap}, 64'h1);
        check("swap_out_data", {48'h0, out_data}, 64'h5);
        idle();
        tick();
        check("load_swap_sum", {32'h0, out_sum}, 64'h1F);
        check("load_swap_valid", {63'h0, out_sum_valid}, 64'h1);
        check("load_swap_err", {63'h0, err_swap_empty}, 64'h0);

        // Tag forwarding, then 2-lane signed with the untouched shadow weight 0xFF02
        wload(16'hFF02, 8'h00);
        tick();
        wload(16'hBEEF, 8'h03);
        tick();
        check("fwd_wload", {63'h0, out_wload}, 64'h1);
        check("fwd_wtag", {56'h0, out_wtag}, 64'h2);
        beat(1'b1, 2'b01, 16'h0304, 32'h0001_0002, 1'b1);
        tick();
        check("lane2_out_mode", {62'h0, out_mode}, 64'h1);
        idle();
        in_wtag = 8'h05;
        tick();
        check("lane2_sum", {32'h0, out_sum}, 64'hFFFE_000A);
        check("lane2_valid", {63'h0, out_sum_valid}, 64'h1);
        check("passtag_wtag", {56'h0, out_wtag}, 64'h5);
        check("passtag_wload", {63'h0, out_wload}, 64'h0);

        // 4-lane wrap: each lane 7*7 + 0xFF = 0x130 -> 0x30
        idle();
        wload(16'h7777, 8'h00);
        tick();
        beat(1'b1, 2'b10, 16'h7777, 32'hFFFF_FFFF, 1'b1);
        tick();
        idle();
        tick();
        check("lane4_wrap_sum", {32'h0, out_sum}, 64'h3030_3030);

        // Mode 11 behaves as full width: 0x7777*2 = 0xEEEE; then 0x7777*(-1) = 0xFFFF8889
        beat(1'b1, 2'b11, 16'h0002, 32'h0, 1'b0);
        tick();
        beat(1'b1, 2'b00, 16'hFFFF, 32'h0, 1'b0);
        tick();
        check("mode11_sum", {32'h0, out_sum}, 64'h0000_EEEE);
        beat(1'b0, 2'b00, 16'h0005, 32'h7, 1'b0);
        tick();
        check("neg_full_sum", {32'h0, out_sum}, 64'hFFFF_8889);
        idle();
        tick();
        check("invalid_sum", {32'h0, out_sum}, 64'h0);
        check("invalid_valid", {63'h0, out_sum_valid}, 64'h0);

        // Stall: beats 1,2,3 against 0x7777; stalled cycles also try a load and a swap
        beat(1'b1, 2'b00, 16'h0001, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            en = 1'b0;
            in_valid = 1'b0; in_wload = 1'b1; in_wtag = 8'h00;
            in_data = 16'h1111; in_wswap = 1'b1;
            tick();
            check("stall_sum_valid", {63'h0, out_sum_valid}, 64'h0);
            check("stall_out_valid", {63'h0, out_valid}, 64'h1);
        end
        en = 1'b1;
        beat(1'b1, 2'b00, 16'h0002, 32'h0, 1'b0);
        tick();
        check("stall_a_sum", {32'h0, out_sum}, 64'h7777);
        check("stall_a_valid", {63'h0, out_sum_valid}, 64'h1);
        beat(1'b1, 2'b00, 16'h0003, 32'h0, 1'b0);
        tick();
        check("stall_b_sum", {32'h0, out_sum}, 64'hEEEE);
        idle();
        tick();
        check("stall_c_sum", {32'h0, out_sum}, 64'h1_6665);
        check("stall_ignored_swap", {63'h0, err_swap_empty}, 64'h0);
        tick();
        check("stall_drain", {63'h0, out_sum_valid}, 64'h0);

        // Reset with shadow full and two beats in flight
        wload(16'h0009, 8'h00);
        tick();
        beat(1'b1, 2'b00, 16'h0001, 32'h0, 1'b0);
        tick();
        beat(1'b1, 2'b00, 16'h0002, 32'h0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_async_sum", {32'h0, out_sum}, 64'h0);
        check("rst_async_sum_valid", {63'h0, out_sum_valid}, 64'h0);
        check("rst_async_valid", {63'h0, out_valid}, 64'h0);
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("rst_release_valid", {63'h0, out_sum_valid}, 64'h0);

        // Swap with empty shadow: active is 0, so sum passes through and the flag sticks
        beat(1'b1, 2'b00, 16'h1234, 32'h5, 1'b1);
        tick();
        check("empty_swap_err", {63'h0, err_swap_empty}, 64'h1);
        idle();
        tick();
        check("empty_swap_sum", {32'h0, out_sum}, 64'h5);
        check("empty_swap_valid", {63'h0, out_sum_valid}, 64'h1);
        repeat (2) tick();
        check("err_sticky", {63'h0, err_swap_empty}, 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
